// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment scanner with a double-buffered frame,
// per-slot anti-ghosting blanking and optional leading-zero suppression.
module display_scanner #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [N_DIGITS*5-1:0] digits_i,
  input  logic                  lzb_i,
  output logic                  ready_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o,
  output logic                  frame_o
);

  localparam int unsigned CntW   = $clog2(DIV);
  localparam int unsigned IdxW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned FrameW = N_DIGITS * 5;

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [FrameW-1:0]   pend_q, pend_d;
  logic [FrameW-1:0]   active_q, active_d;
  logic                valid_q, valid_d;

  logic                slot_end, last_digit, wrap, accept;
  logic [4:0]          cur;
  logic                hide;
  logic                zero_run;
  logic [N_DIGITS-1:0] lz_mask;
  logic [6:0]          seg_dec;

  assign slot_end   = (cnt_q == CntW'(DIV - 1));
  assign last_digit = (idx_q == IdxW'(N_DIGITS - 1));
  assign wrap       = slot_end & last_digit;
  assign accept     = load_i & ~valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StBlank;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank: if (cnt_q == CntW'(BLANK - 1)) state_d = StDrive;
      StDrive: if (slot_end)                   state_d = StBlank;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    pend_d   = pend_q;
    active_d = active_q;
    valid_d  = valid_q;
    if (slot_end) idx_d = last_digit ? '0 : idx_q + 1'b1;
    if (wrap && valid_q) begin
      active_d = pend_q;
      valid_d  = 1'b0;
    end
    // accept only happens with valid_q low, so it never collides with the swap
    if (accept) begin
      pend_d  = digits_i;
      valid_d = 1'b1;
    end
  end

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
      zero_run   = zero_run & (active_q[k*5+1 +: 4] == 4'd0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    cur  = '0;
    hide = 1'b0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (idx_q == IdxW'(k)) begin
        cur  = active_q[k*5 +: 5];
        hide = lz_mask[k];
      end
    end
  end

  always_comb begin
    case (cur[4:1])
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_comb begin
    an_o    = '1;
    seg_o   = 7'b1111111;
    dp_o    = 1'b1;
    frame_o = wrap;
    ready_o = ~valid_q;
    if (state_q == StDrive && !(lzb_i && hide)) begin
      for (int k = 0; k < int'(N_DIGITS); k++) begin
        if (idx_q == IdxW'(k)) an_o[k] = 1'b0;
      end
      seg_o = seg_dec;
      dp_o  = ~cur[0];
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with N_DIGITS=4, DIV=8, BLANK=2.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_i;
  logic [19:0] digits_i;
  logic        lzb_i;
  logic        ready_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  display_scanner #(
    .N_DIGITS(4),
    .DIV     (8),
    .BLANK   (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_i),
    .digits_i(digits_i),
    .lzb_i   (lzb_i),
    .ready_o (ready_o),
    .seg_o   (seg_o),
    .dp_o    (dp_o),
    .an_o    (an_o),
    .frame_o (frame_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // cyc = number of rising edges since reset release
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    load_i   = 1'b0;
    digits_i = '0;
    lzb_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 16'(an_o), 16'hF);
    check("rst_seg", 16'(seg_o), 16'h7F);
    check("rst_dp", 16'(dp_o), 16'h1);
    check("rst_frame", 16'(frame_o), 16'h0);
    check("rst_ready", 16'(ready_o), 16'h1);

    rst_n = 1'b1;
    cyc   = 0;
    check("c0_an", 16'(an_o), 16'hF);
    goto(1);
    check("c1_an", 16'(an_o), 16'hF);
    goto(2);
    check("c2_an", 16'(an_o), 16'hE);
    check("c2_seg_zero", 16'(seg_o), 16'(7'b1000000));
    check("c2_dp", 16'(dp_o), 16'h1);

    // frame {3:1,2:2,1:3,0:4}, then a second load that must be ignored
    check("c2_ready", 16'(ready_o), 16'h1);
    digits_i = {5'b00010, 5'b00100, 5'b00110, 5'b01000};
    load_i   = 1'b1;
    goto(3);
    check("c3_ready_busy", 16'(ready_o), 16'h0);
    digits_i = {4{5'b10001}};
    goto(4);
    load_i = 1'b0;
    check("c4_ready_busy", 16'(ready_o), 16'h0);
    goto(30);
    check("c30_frame", 16'(frame_o), 16'h0);
    goto(31);
    check("c31_frame", 16'(frame_o), 16'h1);
    check("c31_an", 16'(an_o), 16'h7);
    check("c31_seg_old", 16'(seg_o), 16'(7'b1000000));
    goto(32);
    check("c32_ready", 16'(ready_o), 16'h1);
    check("c32_frame", 16'(frame_o), 16'h0);
    check("c32_an", 16'(an_o), 16'hF);
    goto(33);
    check("c33_an", 16'(an_o), 16'hF);
    goto(34);
    check("c34_an", 16'(an_o), 16'hE);
    check("c34_seg4", 16'(seg_o), 16'(7'b0011001));
    check("c34_dp", 16'(dp_o), 16'h1);
    goto(39);
    check("c39_an", 16'(an_o), 16'hE);
    check("c39_seg4", 16'(seg_o), 16'(7'b0011001));
    goto(40);
    check("c40_an", 16'(an_o), 16'hF);
    goto(42);
    check("c42_an", 16'(an_o), 16'hD);
    check("c42_seg3", 16'(seg_o), 16'(7'b0110000));
    goto(58);
    check("c58_an", 16'(an_o), 16'h7);
    check("c58_seg1", 16'(seg_o), 16'(7'b1111001));
    goto(63);
    check("c63_frame", 16'(frame_o), 16'h1);

    // leading-zero blanking on {0,0,0,5}
    goto(64);
    digits_i = {5'b00000, 5'b00000, 5'b00000, 5'b01010};
    load_i   = 1'b1;
    lzb_i    = 1'b1;
    goto(65);
    load_i = 1'b0;
    goto(98);
    check("lz_d0_an", 16'(an_o), 16'hE);
    check("lz_d0_seg5", 16'(seg_o), 16'(7'b0010010));
    goto(106);
    check("lz_d1_an", 16'(an_o), 16'hF);
    goto(114);
    check("lz_d2_an", 16'(an_o), 16'hF);
    goto(122);
    check("lz_d3_an", 16'(an_o), 16'hF);
    lzb_i = 1'b0;
    #1;
    check("nolz_d3_an", 16'(an_o), 16'h7);
    check("nolz_d3_seg", 16'(seg_o), 16'(7'b1000000));

    // load on the wrap cycle, digit 0 = {12, dp}
    goto(127);
    check("c127_frame", 16'(frame_o), 16'h1);
    check("c127_ready", 16'(ready_o), 16'h1);
    digits_i = {15'b0, 5'b11001};
    load_i   = 1'b1;
    goto(128);
    load_i = 1'b0;
    check("c128_ready", 16'(ready_o), 16'h0);
    goto(130);
    check("c130_an", 16'(an_o), 16'hE);
    check("c130_seg_still5", 16'(seg_o), 16'(7'b0010010));
    goto(159);
    check("c159_frame", 16'(frame_o), 16'h1);
    goto(160);
    check("c160_an", 16'(an_o), 16'hF);
    goto(162);
    check("c162_an", 16'(an_o), 16'hE);
    check("c162_seg_blank", 16'(seg_o), 16'h7F);
    check("c162_dp_on", 16'(dp_o), 16'h0);

    // asynchronous reset mid-DRIVE with a pending frame
    digits_i = {5'b00010, 5'b00010, 5'b00010, 5'b00010};
    load_i   = 1'b1;
    goto(163);
    load_i = 1'b0;
    check("c163_ready", 16'(ready_o), 16'h0);
    check("c163_an", 16'(an_o), 16'hE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 16'(an_o), 16'hF);
    check("mid_rst_seg", 16'(seg_o), 16'h7F);
    check("mid_rst_dp", 16'(dp_o), 16'h1);
    check("mid_rst_ready", 16'(ready_o), 16'h1);
    check("mid_rst_frame", 16'(frame_o), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    goto(2);
    check("r2_an", 16'(an_o), 16'hE);
    check("r2_seg_zero", 16'(seg_o), 16'(7'b1000000));
    goto(34);
    check("r34_an", 16'(an_o), 16'hE);
    check("r34_seg_zero", 16'(seg_o), 16'(7'b1000000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
